// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with byte lanes and word-crossing split access
module load_store_unit #(
    parameter int MEM_AW = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [MEM_AW-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t             state, state_nx;
    logic               write_q;
    logic [2:0]         funct3_q;
    logic [MEM_AW+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               illegal_q;
    logic [31:0]        lo_q, hi_q;

    logic               accept;
    logic               illegal_in;
    logic [1:0]         off;
    logic [3:0]         size_mask;
    logic [7:0]         mask;
    logic [MEM_AW-1:0]  word_addr;
    logic [63:0]        shifted;
    logic               unused_ok;

    assign accept     = req_valid && (state == IDLE);
    assign illegal_in = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                     || (req_write && (req_funct3[2:1] == 2'b10));

    assign off       = addr_q[1:0];
    assign word_addr = addr_q[MEM_AW+1:2];
    assign size_mask = (funct3_q[1:0] == 2'b00) ? 4'h1 :
                       (funct3_q[1:0] == 2'b01) ? 4'h3 : 4'hF;
    assign mask      = {4'b0000, size_mask} << off;
    assign shifted   = {hi_q, lo_q} >> {off, 3'b000};
    assign unused_ok = ^{req_addr[31:MEM_AW+2], shifted[63:32]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = illegal_in ? RESP : ACC0;
            ACC0: state_nx = (mask[7:4] != 4'h0) ? ACC1 : RESP;
            ACC1: state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields are held for the whole transaction; read buffers fill per access phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q   <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            illegal_q <= 1'b0;
            lo_q      <= 32'h0;
            hi_q      <= 32'h0;
        end else if (accept) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr[MEM_AW+1:0];
            wdata_q   <= req_wdata;
            illegal_q <= illegal_in;
            lo_q      <= 32'h0;
            hi_q      <= 32'h0;
        end else if (state == ACC0 && !write_q) begin
            lo_q <= mem_q;
        end else if (state == ACC1 && !write_q) begin
            hi_q <= mem_q;
        end
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = 1'b0;
        resp_error  = 1'b0;
        resp_rdata  = 32'h0;
        mem_address = '0;
        mem_byteena = 4'h0;
        mem_data    = 32'h0;
        mem_wren    = 1'b0;
        case (state)
            ACC0: begin
                mem_address = word_addr;
                mem_byteena = mask[3:0];
                mem_data    = wdata_q << {off, 3'b000};
                mem_wren    = write_q;
            end
            ACC1: begin
                mem_address = word_addr + 1'b1;
                mem_byteena = mask[7:4];
                mem_data    = wdata_q >> (6'd32 - {1'b0, off, 3'b000});
                mem_wren    = write_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = illegal_q;
                if (!illegal_q && !write_q) begin
                    case (funct3_q)
                        3'b000:  resp_rdata = {{24{shifted[7]}}, shifted[7:0]};
                        3'b001:  resp_rdata = {{16{shifted[15]}}, shifted[15:0]};
                        3'b100:  resp_rdata = {24'h0, shifted[7:0]};
                        3'b101:  resp_rdata = {16'h0, shifted[15:0]};
                        default: resp_rdata = shifted[31:0];
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int MEM_AW = 14;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready, req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_error;
    logic [31:0]       resp_rdata;
    logic [MEM_AW-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data, mem_q;
    logic              mem_wren;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    bit [31:0] mem  [0:(1<<MEM_AW)-1];
    bit [7:0]  refb [0:(1<<(MEM_AW+2))-1];

    assign mem_q = mem[mem_address];
    always @(posedge clock) begin
        if (mem_wren)
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    end

    int total = 0, bad = 0;
    int idle_viol = 0, resp_cnt = 0, wren_cnt = 0;

    always @(negedge clock) begin
        if (!resp_valid && (resp_rdata != 32'h0 || resp_error)) idle_viol++;
        if (resp_valid) resp_cnt++;
        if (mem_wren) wren_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_illegal(input logic w, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
            || (w && (f3 == 3'b100 || f3 == 3'b101));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] a);
        logic [31:0] v = 32'h0;
        logic [15:0] idx;
        int n = size_of(f3);
        for (int i = 0; i < n; i++) begin
            idx = a + 16'(i);
            v = v | (32'(refb[idx]) << (8*i));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 4; i++) v = v | (32'(refb[widx*4 + i]) << (8*i));
        return v;
    endfunction

    logic [31:0] cap_a0, cap_be0, cap_d0, cap_w0, cap_a1, cap_be1, cap_d1;
    logic [31:0] last_rd, last_lat;

    // Caller is 1 time unit after a rising edge with the unit idle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic er, output logic vld_after, output logic rdy_after);
        lat = 0; rd = 32'hX; er = 1'bX;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        for (int n = 1; n <= 6; n++) begin
            if (n == 1) begin
                cap_a0 = 32'(mem_address); cap_be0 = 32'(mem_byteena);
                cap_d0 = mem_data; cap_w0 = 32'(mem_wren);
            end else if (n == 2) begin
                cap_a1 = 32'(mem_address); cap_be1 = 32'(mem_byteena); cap_d1 = mem_data;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_error;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        vld_after = resp_valid; rdy_after = req_ready;
    endtask

    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int          lat, exp_lat, n, w0;
        logic [31:0] rd, exp_rd;
        logic        er, va, ra, ill;
        logic [15:0] a16, idx;
        a16 = a[15:0];
        ill = is_illegal(w, f3);
        n = size_of(f3);
        exp_lat = ill ? 1 : ((int'(a16[1:0]) + n > 4) ? 3 : 2);
        exp_rd  = (ill || w) ? 32'h0 : ref_load(f3, a16);
        w0 = wren_cnt;
        do_req(w, f3, a, d, lat, rd, er, va, ra);
        last_rd = rd; last_lat = 32'(lat);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", rd, exp_rd);
        check("error", 32'(er), 32'(ill));
        check("pulse_len", 32'(va), 32'h0);
        check("ready_after", 32'(ra), 32'h1);
        check("wren_cycles", 32'(wren_cnt - w0), (w && !ill) ? 32'(exp_lat - 1) : 32'h0);
        if (w && !ill) begin
            for (int i = 0; i < n; i++) begin
                idx = a16 + 16'(i);
                refb[idx] = d[8*i +: 8];
            end
            for (int i = 0; i < n; i++) begin
                idx = a16 + 16'(i);
                check("store_byte", 32'(mem[idx[15:2]][8*idx[1:0] +: 8]), 32'(refb[idx]));
            end
        end
    endtask

    initial begin
        int          r0, w0;
        logic [31:0] r, r2;
        logic [15:0] a16;

        reset_n = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp", 32'(resp_valid), 32'h0);
        check("rst_wren", 32'(mem_wren), 32'h0);
        check("rst_be", 32'(mem_byteena), 32'h0);
        check("rst_addr", 32'(mem_address), 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        do_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_a0", cap_a0, 32'h40);
        check("sw_be0", cap_be0, 32'hF);
        check("sw_d0", cap_d0, 32'hDEAD_BEEF);
        check("sw_w0", cap_w0, 32'h1);
        check("sw_lat", last_lat, 32'd2);

        do_op(1'b1, 3'b010, 32'h0000_0100, 32'h80FF_0000);
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        check("lb_be0", cap_be0, 32'h8);
        check("lb_rd", last_rd, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        check("lbu_rd", last_rd, 32'h0000_0080);

        do_op(1'b1, 3'b001, 32'h0000_0103, 32'h0000_ABCD);
        check("sh_a0", cap_a0, 32'h40);
        check("sh_be0", cap_be0, 32'h8);
        check("sh_d0", cap_d0, 32'hCD00_0000);
        check("sh_a1", cap_a1, 32'h41);
        check("sh_be1", cap_be1, 32'h1);
        check("sh_d1", cap_d1, 32'h0000_00AB);
        check("sh_lat", last_lat, 32'd3);

        do_op(1'b1, 3'b010, 32'h0000_0100, 32'h4433_2211);
        do_op(1'b1, 3'b010, 32'h0000_0104, 32'h8877_6655);
        do_op(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        check("lw_cross_rd", last_rd, 32'h6655_4433);

        do_op(1'b1, 3'b010, 32'h0000_FFFC, 32'hA1B2_C3D4);
        do_op(1'b1, 3'b010, 32'h0000_0000, 32'h1122_3344);
        do_op(1'b0, 3'b010, 32'h0000_FFFD, 32'h0);
        check("wrap_a0", cap_a0, 32'h3FFF);
        check("wrap_a1", cap_a1, 32'h0);
        check("wrap_rd", last_rd, 32'h44A1_B2C3);

        do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        check("ill_be0", cap_be0, 32'h0);
        check("ill_w0", cap_w0, 32'h0);
        check("ill_err_lat", last_lat, 32'd1);

        // Misaligned store cut off by reset while its first word is being driven.
        r0 = resp_cnt; w0 = wren_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0201; req_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        check("abort_in_acc0", 32'(mem_wren), 32'h1);
        reset_n = 1'b0; #1;
        check("abort_wren", 32'(mem_wren), 32'h0);
        check("abort_be", 32'(mem_byteena), 32'h0);
        check("abort_addr", 32'(mem_address), 32'h0);
        check("abort_data", mem_data, 32'h0);
        check("abort_ready", 32'(req_ready), 32'h1);
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_resp", 32'(resp_cnt - r0), 32'h0);
        check("abort_no_wren", 32'(wren_cnt - w0), 32'h0);
        check("abort_w80", mem[14'h80], ref_word(32'h80));
        check("abort_w81", mem[14'h81], ref_word(32'h81));

        for (int k = 0; k < 300; k++) begin
            r = $urandom; r2 = $urandom;
            a16 = (r[7] ? 16'hFFC0 : 16'h0000) | {10'b0, r[13:8]};
            do_op(r[0], r[3:1], {r2[31:16], a16}, r2);
        end

        check("idle_outputs_zero", 32'(idle_viol), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, meaning word-address width of the data memory port (byte space 2^(MEM_AW+2)).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address, low MEM_AW+2 bits used.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result, 0 for stores/errors.
REQ-012 SHALL have port resp_error  output  1  illegal width code, qualified by resp_valid.
REQ-013 SHALL have ports mem_address output MEM_AW, mem_byteena output 4, mem_data output 32, mem_wren output 1, mem_q input 32 (asynchronous read of mem_address; write on clock edge when mem_wren).

Function
REQ-014 SHALL implement FSM states IDLE, ACC0, ACC1, RESP; req_ready = (state==IDLE).
REQ-015 SHALL accept on rising edge with req_valid && req_ready, latching write, funct3, addr, wdata; req_valid outside IDLE ignored.
REQ-016 SHALL classify illegal: funct3 in {011,110,111}, or write with funct3 in {100,101}; illegal goes IDLE->RESP, no memory access.
REQ-017 SHALL form 8-bit mask M = size mask (B 0x1, H 0x3, W 0xF) << off, off = addr[1:0].
REQ-018 ACC0: mem_address = addr[MEM_AW+1:2], mem_byteena = M[3:0], mem_data = wdata << 8*off, mem_wren = write; loads capture mem_q into lo buffer.
REQ-019 ACC0 -> ACC1 if M[7:4] != 0 (word crossing), else -> RESP.
REQ-020 ACC1: mem_address = ACC0 address + 1 modulo 2^MEM_AW (wraps to 0), mem_byteena = M[7:4], mem_data = wdata >> 8*(4-off), mem_wren = write; loads capture mem_q into hi buffer; -> RESP.
REQ-021 RESP: resp_valid = 1 for exactly one cycle, then -> IDLE; resp_rdata = ({hi,lo} >> 8*off) truncated to size, sign-extended for 000/001, zero-extended for 010/100/101.
REQ-022 Outside ACC0/ACC1: mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
REQ-023 Latency from accept edge: aligned/in-word access resp_valid in 2nd following cycle; word-crossing 3rd; illegal 1st.
REQ-024 resp_rdata and resp_error SHALL be 0 whenever resp_valid=0.
REQ-025 New request acceptable in cycle immediately after RESP (throughput one request per 3 cycles aligned).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, req_ready=1, all other outputs 0, buffers cleared.
REQ-027 Reset during ACC0/ACC1 SHALL abort: no further memory write issued; bytes already written are not restored; no resp_valid.

Verification
REQ-028 SW 0x100, 0xDEADBEEF -> ACC0 mem_address 0x40, byteena 1111, data 0xDEADBEEF, wren 1; resp_valid 2 cycles after accept, rdata 0.
REQ-029 LB / LBU 0x103, word[0x40]=0x80FF0000 -> byteena 1000; rdata 0xFFFFFF80 / 0x00000080.
REQ-030 SH 0x103, 0x0000ABCD -> ACC0 addr 0x40 be 1000 data 0xCD000000; ACC1 addr 0x41 be 0001 data 0x000000AB; resp 3 cycles after accept.
REQ-031 LW 0x102, word[0x40]=0x44332211, word[0x41]=0x88776655 -> rdata 0x66554433; LW at top word+1 wraps ACC1 address to 0.
REQ-032 funct3 011 load -> no wren/byteena ever, resp_valid 1 cycle after accept, resp_error 1, rdata 0.
REQ-033 reset_n pulsed low during ACC0 of misaligned SW -> outputs 0 at once, no ACC1 write, req_ready 1, no resp_valid.
